uart_rx_pro: RTL and testbench

UART_RX_PRO -- requirements
Module: uart_rx_pro

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_pro.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_pro.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the uart_rx_pro receiver slice.
//   rx_state_t    - receiver FSM states
//   parity_mode_t - encoding of the parity_mode input
//   rx_entry_t    - one FIFO word: status flags plus payload (sized for the
//                   largest legal payload; narrower payloads leave the top bits 0)
package uart_pkg;

  localparam int unsigned MAX_PAYLOAD = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_EVEN     = 2'd1,
    PAR_ODD      = 2'd2,
    PAR_NONE_ALT = 2'd3
  } parity_mode_t;

  typedef struct packed {
    logic                   brk;
    logic                   parity_err;
    logic                   frame_err;
    logic [MAX_PAYLOAD-1:0] data;
  } rx_entry_t;

  localparam int unsigned ENTRY_W = $bits(rx_entry_t);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO, power-of-two depth.
//   clk, resetn     - clock, synchronous active-low reset
//   push, din       - write request and data; ignored when full unless popping
//   pop             - read request; ignored when empty
//   dout            - head word (valid while empty = 0)
//   full, empty     - occupancy flags
//   count           - number of stored words
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the head slot, which is exactly wr_ptr.
  assign do_push = push & (~full | pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_pro.sv
// uart_rx_pro: UART receiver with 2-of-3 mid-bit voting, optional parity,
// break detection and an output FIFO.
//   clk, resetn      - clock, synchronous active-low reset
//   uart_rxd         - asynchronous serial line, idle high
//   uart_rx_en       - receive enable; low aborts any frame in progress
//   parity_mode      - 0 none, 1 even, 2 odd, 3 none; latched while idle
//   m_valid/m_ready  - head-word handshake
//   m_data           - head payload, LSB = first bit on the line
//   m_frame_err, m_parity_err, m_break - head-word status
//   overflow         - one-cycle pulse when a completed word was dropped
//   fifo_count       - stored word count
// Build option: define UART_RX_PARITY_EN to enable the parity bit; without it
// parity_mode is ignored and m_parity_err is always 0.
module uart_rx_pro
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  input  logic                          uart_rx_en,
  input  logic [1:0]                    parity_mode,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [PAYLOAD_BITS-1:0]       m_data,
  output logic                          m_frame_err,
  output logic                          m_parity_err,
  output logic                          m_break,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CPB   = CLK_HZ / BIT_RATE;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned MID   = CPB / 2;
  localparam int unsigned BIT_W = $clog2(PAYLOAD_BITS);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_S0  = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_S1  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_S2  = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CPB - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  rx_state_t               state, state_next;
  logic                    sync1, rxs;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        bit_idx;
  logic                    stop_idx;
  logic                    s_a, s_b;
  logic                    maj, at_mid, at_end;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic                    frame_err_q, frame_err_now;
  logic                    parity_err_q, par_bit_q, par_en;
  logic                    push, pop, full, empty;
  rx_entry_t               push_entry, head;
  logic [ENTRY_W-1:0]      push_bits, head_bits;
  logic                    unused_bits;

  always_ff @(posedge clk) begin
    if (!resetn || !uart_rx_en) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      rxs   <= sync1;
    end
  end

  // The decision cycle (cnt == MID+1) votes two stored samples with the live one.
  assign maj    = maj3(s_a, s_b, rxs);
  assign at_mid = (cnt == CNT_S2);
  assign at_end = (cnt == CNT_END);

`ifdef UART_RX_PARITY_EN
  parity_mode_t par_mode_q;
  logic         par_expect;

  assign par_en     = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);
  assign par_expect = (par_mode_q == PAR_ODD) ? ~^shreg : ^shreg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      par_mode_q   <= PAR_NONE;
      parity_err_q <= 1'b0;
      par_bit_q    <= 1'b0;
    end else if (state == S_IDLE) begin
      par_mode_q   <= parity_mode_t'(parity_mode);
      parity_err_q <= 1'b0;
      par_bit_q    <= 1'b0;
    end else if (state == S_PARITY && at_mid) begin
      par_bit_q    <= maj;
      parity_err_q <= maj ^ par_expect;
    end
  end
`else
  assign par_en       = 1'b0;
  assign parity_err_q = 1'b0;
  assign par_bit_q    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next    = state;
    push          = 1'b0;
    frame_err_now = frame_err_q | (state == S_STOP && at_mid && !maj);
    push_entry    = '0;
    push_entry.data[PAYLOAD_BITS-1:0] = shreg;
    push_entry.frame_err  = frame_err_now;
    push_entry.parity_err = parity_err_q;
    push_entry.brk        = frame_err_now && (shreg == '0) && !par_bit_q;
    unique case (state)
      S_IDLE:      if (!rxs) state_next = S_START;
      S_START:     if (at_mid && maj) state_next = S_IDLE;
                   else if (at_end)   state_next = S_DATA;
      S_DATA:      if (at_end && bit_idx == BIT_LAST)
                     state_next = par_en ? S_PARITY : S_STOP;
      S_PARITY:    if (at_end) state_next = S_STOP;
      S_STOP:      if (at_mid && stop_idx == STOP_LAST) begin
                     push       = 1'b1;
                     state_next = frame_err_now ? S_WAIT_IDLE : S_IDLE;
                   end
      S_WAIT_IDLE: if (rxs) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (!uart_rx_en) begin
      state_next = S_IDLE;
      push       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt         <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      s_a         <= 1'b1;
      s_b         <= 1'b1;
      shreg       <= '0;
      frame_err_q <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      overflow <= push & full & ~pop;
      // IDLE already spent one cycle of the start bit detecting the edge.
      if (state_next != state)
        cnt <= (state_next == S_START) ? CNT_ONE : '0;
      else if (state == S_IDLE || state == S_WAIT_IDLE || at_end)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (cnt == CNT_S0) s_a <= rxs;
      if (cnt == CNT_S1) s_b <= rxs;
      if (state != S_DATA) bit_idx <= '0;
      else if (at_end)     bit_idx <= bit_idx + 1'b1;
      if (state != S_STOP) stop_idx <= 1'b0;
      else if (at_end)     stop_idx <= 1'b1;
      if (state == S_DATA && at_mid)
        shreg <= {maj, shreg[PAYLOAD_BITS-1:1]};
      if (state == S_IDLE)
        frame_err_q <= 1'b0;
      else if (state == S_STOP && at_mid && !maj)
        frame_err_q <= 1'b1;
    end
  end

  assign push_bits = push_entry;
  assign head      = rx_entry_t'(head_bits);
  assign pop       = m_valid & m_ready;

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (push_bits),
    .pop    (pop),
    .dout   (head_bits),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  // Head storage is unreset, so outputs are gated to read 0 while empty.
  assign m_valid     = ~empty;
  assign m_data      = m_valid ? head.data[PAYLOAD_BITS-1:0] : '0;
  assign m_frame_err = m_valid & head.frame_err;
  assign m_break     = m_valid & head.brk;
`ifdef UART_RX_PARITY_EN
  assign m_parity_err = m_valid & head.parity_err;
`else
  assign m_parity_err = 1'b0;
`endif
  assign unused_bits = ^{head_bits, parity_mode};

endmodule

// File: tb/tb_uart_rx_pro.sv
// tb_uart_rx_pro: directed bench for uart_rx_pro at 10 clocks per bit.
module tb_uart_rx_pro;

  localparam int unsigned CPB = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_en = 1'b0;
  logic [1:0] parity_mode = 2'd0;
  logic       m_ready = 1'b0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_frame_err, m_parity_err, m_break, overflow;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_fail = 0;
  int valid_cycles = 0;
  int ovf_cnt = 0;
  logic [10:0] rx_q [$];

  uart_rx_pro #(
    .CLK_HZ       (50_000_000),
    .BIT_RATE     (5_000_000),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .uart_rxd     (uart_rxd),
    .uart_rx_en   (uart_rx_en),
    .parity_mode  (parity_mode),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_frame_err  (m_frame_err),
    .m_parity_err (m_parity_err),
    .m_break      (m_break),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge; everything is observed on negedge.
  always @(negedge clk) begin
    if (resetn) begin
      if (m_valid && m_ready) rx_q.push_back({m_break, m_parity_err, m_frame_err, m_data});
      if (m_valid) valid_cycles++;
      if (overflow) ovf_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    uart_rxd = b;
    tick(CPB);
  endtask

  // par < 0 means no parity bit on the line.
  task automatic send_frame(input logic [7:0] d, input int par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par >= 0) send_bit(par[0]);
    send_bit(1'b1);
  endtask

  function automatic logic [10:0] take();
    logic [10:0] w;
    w = 'x;
    if (rx_q.size() > 0) w = rx_q.pop_front();
    return w;
  endfunction

  task automatic test_reset;
    resetn = 1'b0;
    uart_rx_en = 1'b0;
    tick(3);
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    n_cmp++; if (m_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", m_frame_err); end
    n_cmp++; if (m_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b want 0", m_parity_err); end
    n_cmp++; if (m_break !== 1'b0) begin n_fail++; $display("FAIL reset_break: got %b want 0", m_break); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    resetn = 1'b1;
    uart_rx_en = 1'b1;
    tick(5);
  endtask

  task automatic test_basic;
    logic [10:0] w;
    m_ready = 1'b1;
    parity_mode = 2'd0;
    rx_q.delete();
    valid_cycles = 0;
    send_frame(8'hA5, -1);
    tick(2 * CPB);
    n_cmp++; if (rx_q.size() !== 1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", rx_q.size()); end
    w = take();
    n_cmp++; if (w !== 11'h0A5) begin n_fail++; $display("FAIL basic_word: got %h want 0a5", w); end
    n_cmp++; if (valid_cycles !== 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", valid_cycles); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL basic_fifo_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_parity;
    logic [1:0]  modes [3];
    int          pbits [3];
    logic [10:0] exp_w [3];
    logic [10:0] w;
    modes = '{2'd1, 2'd1, 2'd2};
    pbits = '{1, 0, 1};
`ifdef UART_RX_PARITY_EN
    exp_w = '{11'h23C, 11'h03C, 11'h03C};
`else
    // The extra bit lands in the stop slot: a 0 there is a framing error.
    exp_w = '{11'h03C, 11'h13C, 11'h03C};
`endif
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_q.delete();
      parity_mode = modes[i];
      tick(2);
      send_frame(8'h3C, pbits[i]);
      tick(2 * CPB);
      w = take();
      n_cmp++; if (w !== exp_w[i]) begin n_fail++; $display("FAIL parity_case%0d: got %h want %h", i, w, exp_w[i]); end
    end
    parity_mode = 2'd0;
    tick(2);
  endtask

  task automatic test_break;
    logic [10:0] w;
    m_ready = 1'b1;
    rx_q.delete();
    uart_rxd = 1'b0;
    tick(11 * CPB);
    n_cmp++; if (rx_q.size() !== 1) begin n_fail++; $display("FAIL break_count_low: got %0d want 1", rx_q.size()); end
    tick(CPB);
    uart_rxd = 1'b1;
    tick(3 * CPB);
    n_cmp++; if (rx_q.size() !== 1) begin n_fail++; $display("FAIL break_count_after: got %0d want 1", rx_q.size()); end
    w = take();
    n_cmp++; if (w !== 11'h500) begin n_fail++; $display("FAIL break_word: got %h want 500", w); end
  endtask

  task automatic test_back_to_back_overflow;
    int          ovf0;
    logic [10:0] w;
    m_ready = 1'b0;
    rx_q.delete();
    ovf0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), -1);
    tick(2 * CPB);
    @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_fifo_count: got %0d want 4", fifo_count); end
    n_cmp++; if (ovf_cnt - ovf0 !== 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt - ovf0); end
    n_cmp++; if (m_data !== 8'h01) begin n_fail++; $display("FAIL ovf_head_stable: got %h want 01", m_data); end
    tick(1);
    m_ready = 1'b1;
    tick(8);
    n_cmp++; if (rx_q.size() !== 4) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want 4", rx_q.size()); end
    for (int i = 1; i <= 4; i++) begin
      w = take();
      n_cmp++; if (w !== 11'(i)) begin n_fail++; $display("FAIL ovf_drain_word%0d: got %h want %h", i, w, 11'(i)); end
    end
    n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL ovf_drained_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_glitch;
    logic [10:0] w;
    m_ready = 1'b1;
    rx_q.delete();
    uart_rxd = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(3 * CPB);
    n_cmp++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL glitch_no_word: got %0d want 0", rx_q.size()); end
    send_frame(8'h5A, -1);
    tick(2 * CPB);
    w = take();
    n_cmp++; if (w !== 11'h05A) begin n_fail++; $display("FAIL glitch_recover: got %h want 05a", w); end
  endtask

  task automatic test_abort;
    logic [10:0] w;
    m_ready = 1'b0;
    rx_q.delete();
    send_frame(8'h81, -1);
    tick(CPB);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    uart_rx_en = 1'b0;
    uart_rxd = 1'b1;
    tick(2 * CPB);
    uart_rx_en = 1'b1;
    tick(2 * CPB);
    @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL abort_fifo_count: got %0d want 1", fifo_count); end
    n_cmp++; if (m_data !== 8'h81) begin n_fail++; $display("FAIL abort_fifo_kept: got %h want 81", m_data); end
    tick(1);
    m_ready = 1'b1;
    tick(4);
    n_cmp++; if (rx_q.size() !== 1) begin n_fail++; $display("FAIL abort_drain_count: got %0d want 1", rx_q.size()); end
    w = take();
    n_cmp++; if (w !== 11'h081) begin n_fail++; $display("FAIL abort_drain_word: got %h want 081", w); end
    send_frame(8'h7E, -1);
    tick(2 * CPB);
    w = take();
    n_cmp++; if (w !== 11'h07E) begin n_fail++; $display("FAIL abort_recover: got %h want 07e", w); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_back_to_back_overflow();
    test_glitch();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
